// File: rtl/axi_llc_refill_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_refill_sched_if
// Purpose  : Bundle of requester, refill-unit and status signals used by the
//            LLC refill scheduler.
// Ports    : req_desc/req_valid/req_ready  - NUM_REQ descriptor requesters
//            refill_desc/valid/ready       - descriptor channel to refill unit
//            done                          - one refill retired
//            flush                         - block new grants while high
//            outstanding/idle              - scheduler status
// Modports : slave  - scheduler side
//            master - environment side (requesters + refill unit)
// Revision : 1.0 - initial release
// ============================================================================
interface axi_llc_refill_sched_if #(
  parameter int  NUM_REQ         = 2,
  parameter int  MAX_OUTSTANDING = 4,
  parameter type desc_t          = logic
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  desc_t              req_desc [NUM_REQ];
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  desc_t              refill_desc;
  logic               refill_valid;
  logic               refill_ready;
  logic               done;
  logic               flush;
  logic [CNT_W-1:0]   outstanding;
  logic               idle;

  modport slave (
    input  req_desc, req_valid, refill_ready, done, flush,
    output req_ready, refill_desc, refill_valid, outstanding, idle
  );

  modport master (
    output req_desc, req_valid, refill_ready, done, flush,
    input  req_ready, refill_desc, refill_valid, outstanding, idle
  );
endinterface
`default_nettype wire

// File: rtl/axi_llc_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : axi_llc_refill_sched
// Purpose  : Round-robin scheduler of refill descriptors from NUM_REQ miss
//            sources onto a single refill unit. Grants are locked until the
//            refill unit accepts, refills in flight are counted and new
//            grants are throttled at MAX_OUTSTANDING, and a level flush
//            blocks new grants so the refill path can drain.
// Ports    : clk_i   - clock
//            rst_ni  - asynchronous reset, active low
//            bus     - axi_llc_refill_sched_if.slave (requesters, refill
//                      descriptor channel, done, flush, outstanding, idle)
// Revision : 1.0 - initial release
// ============================================================================
module axi_llc_refill_sched #(
  parameter int  NUM_REQ         = 2,
  parameter int  MAX_OUTSTANDING = 4,
  parameter type desc_t          = logic
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  axi_llc_refill_sched_if.slave bus
);

  localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   prio_q, prio_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               any_valid;
  logic [IDX_W-1:0]   winner;
  logic               can_issue;
  logic [IDX_W-1:0]   sel;
  logic               refill_valid;
  logic [NUM_REQ-1:0] req_ready;
  desc_t              refill_desc;
  logic               handshake;

  // Successor in round-robin order; with a single requester this is always 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == C_LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Round-robin pick: scan prio_q, prio_q+1, ... mod NUM_REQ. The loop runs
  // from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    logic [IDX_W:0] cand;
    cand      = '0;
    any_valid = 1'b0;
    winner    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, prio_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (bus.req_valid[cand[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  // rst_ni is folded in so that no grant is offered while reset is held,
  // even though requesters may still present valid descriptors.
  assign can_issue = rst_ni && (cnt_q < C_CNT_MAX) && !bus.flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    sel          = '0;
    refill_valid = 1'b0;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (can_issue && any_valid) begin
          sel               = winner;
          refill_valid      = 1'b1;
          req_ready[winner] = bus.refill_ready;
          if (bus.refill_ready) begin
            prio_d = next_idx(winner);
          end else begin
            gnt_d   = winner;
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        // Credit was checked when the grant was made; flush and the counter
        // are ignored here so that valid never drops before the handshake.
        sel              = gnt_q;
        refill_valid     = 1'b1;
        req_ready[gnt_q] = bus.refill_ready;
        if (bus.refill_ready) begin
          prio_d  = next_idx(gnt_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refill_desc = '0;
    if (refill_valid) begin
      refill_desc = bus.req_desc[sel];
    end
  end

  assign handshake = refill_valid && bus.refill_ready;

  // Handshake and done in the same cycle cancel. A done with nothing in
  // flight is a protocol error; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({handshake, bus.done})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.refill_valid = refill_valid;
  assign bus.refill_desc  = refill_desc;
  assign bus.req_ready    = req_ready;
  assign bus.outstanding  = cnt_q;
  assign bus.idle         = (state_q == IDLE) && (cnt_q == '0) && !refill_valid;

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.req_ready));

  a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.refill_valid && !bus.refill_ready) |=> bus.refill_valid);

  a_desc_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.refill_valid && !bus.refill_ready) |=> $stable(bus.refill_desc));

  a_done_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.done && (cnt_q == '0)));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(handshake && (cnt_q == C_CNT_MAX)));

endmodule
`default_nettype wire

// File: tb/tb_axi_llc_refill_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_llc_refill_sched
// Purpose  : Self-checking bench for axi_llc_refill_sched. Directed scenarios
//            (reset, round robin, grant lock, throttle, simultaneous
//            handshake/done, flush, reset mid-lock) followed by randomized
//            traffic, all compared against a behavioural reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_llc_refill_sched;

  localparam int N    = 3;
  localparam int MAXO = 4;
  typedef logic [7:0] desc_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_llc_refill_sched_if #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .desc_t(desc_t)) bus ();

  axi_llc_refill_sched #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .desc_t(desc_t)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending locked grant (-1 none), rotating priority,
  // refills in flight, and the requester-side view of who is waiting.
  int           m_prio;
  int           m_lock;
  int           m_cnt;
  logic [N-1:0] rv;
  desc_t        rd [N];

  logic         obs_valid;
  logic [N-1:0] obs_ready;
  desc_t        obs_desc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_lock = -1;
    m_cnt  = 0;
  endtask

  // One clock cycle: called just after a rising edge, applies inputs, checks
  // outputs at the falling edge, then advances the model across the edge.
  task automatic cycle(input logic [N-1:0] want, input logic rdy, input logic dn, input logic fl);
    int           w;
    logic         dn_eff;
    logic         e_valid;
    desc_t        e_desc;
    logic [N-1:0] e_ready;
    logic         e_idle;
    for (int i = 0; i < N; i++) begin
      if (!rv[i] && want[i]) begin
        rv[i] = 1'b1;
        rd[i] = desc_t'($urandom);
      end
      bus.req_desc[i] = rd[i];
    end
    dn_eff           = dn && (m_cnt > 0);
    bus.req_valid    = rv;
    bus.refill_ready = rdy;
    bus.done         = dn_eff;
    bus.flush        = fl;

    w = -1;
    if (m_lock >= 0) begin
      w = m_lock;
    end else if (m_cnt < MAXO && !fl) begin
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_prio + off) % N;
        if (w < 0 && rv[idx]) w = idx;
      end
    end
    e_valid = (w >= 0);
    e_desc  = '0;
    e_ready = '0;
    if (e_valid) begin
      e_desc = rd[w];
      if (rdy) e_ready[w] = 1'b1;
    end
    e_idle = (m_lock < 0) && (m_cnt == 0) && !e_valid;

    @(negedge clk);
    obs_valid = bus.refill_valid;
    obs_ready = bus.req_ready;
    obs_desc  = bus.refill_desc;
    check("refill_valid", 32'(obs_valid), 32'(e_valid));
    check("refill_desc", 32'(obs_desc), 32'(e_desc));
    check("req_ready", 32'(obs_ready), 32'(e_ready));
    check("outstanding", 32'(bus.outstanding), 32'(m_cnt));
    check("idle", 32'(bus.idle), 32'(e_idle));

    if (e_valid && rdy) begin
      m_prio = (w + 1) % N;
      m_lock = -1;
      m_cnt++;
      rv[w]  = 1'b0;
    end else if (e_valid) begin
      m_lock = w;
    end
    if (dn_eff) m_cnt--;

    @(posedge clk);
    #1;
    bus.req_valid = rv;
    bus.done      = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rv != '0 || m_cnt != 0 || m_lock >= 0) && guard < 40) begin
      cycle('0, 1'b1, 1'b1, 1'b0);
      guard++;
    end
    check("drain_idle", 32'(bus.idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic  fl;
    desc_t d0;
    model_reset();
    rv = '0;
    for (int i = 0; i < N; i++) begin
      rd[i]           = '0;
      bus.req_desc[i] = '0;
    end
    bus.req_valid    = '0;
    bus.refill_ready = 1'b0;
    bus.done         = 1'b0;
    bus.flush        = 1'b0;

    // Reset values
    #1;
    check("rst_valid", 32'(bus.refill_valid), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_desc", 32'(bus.refill_desc), 32'd0);
    check("rst_out", 32'(bus.outstanding), 32'd0);
    check("rst_idle", 32'(bus.idle), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round robin with a retirement every cycle after the first
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("rr_gnt0", 32'(obs_ready), 32'b001);
    for (int k = 0; k < 3; k++) begin
      cycle(3'b011, 1'b1, 1'b1, 1'b0);
      check("rr_gnt", 32'(obs_ready), (k % 2 == 0) ? 32'b010 : 32'b001);
      check("rr_out", 32'(bus.outstanding), 32'd1);
    end
    drain();

    // Grant lock: req0 held while the refill unit stalls, req1 arrives late
    cycle(3'b001, 1'b0, 1'b0, 1'b0);
    d0 = rd[0];
    cycle(3'b011, 1'b0, 1'b0, 1'b0);
    check("lock_desc1", 32'(obs_desc), 32'(d0));
    cycle(3'b011, 1'b0, 1'b0, 1'b0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("lock_hs_ready", 32'(obs_ready), 32'b001);
    check("lock_hs_desc", 32'(obs_desc), 32'(d0));
    cycle(3'b000, 1'b1, 1'b0, 1'b0);
    check("lock_next", 32'(obs_ready), 32'b010);
    drain();

    // Throttle at MAXO refills in flight
    repeat (6) cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("thr_out", 32'(bus.outstanding), 32'd4);
    check("thr_valid", 32'(bus.refill_valid), 32'd0);
    cycle(3'b011, 1'b1, 1'b1, 1'b0);
    check("thr_done_cycle", 32'(obs_valid), 32'd0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("thr_resume", 32'(obs_valid), 32'd1);
    drain();

    // Handshake and done in the same cycle
    repeat (2) cycle(3'b001, 1'b1, 1'b0, 1'b0);
    cycle(3'b001, 1'b1, 1'b1, 1'b0);
    check("sim_hs", 32'(obs_valid), 32'd1);
    check("sim_out", 32'(bus.outstanding), 32'd2);
    drain();

    // Flush drains the path, then grants resume
    repeat (3) cycle(3'b001, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(3'b011, 1'b1, 1'b1, 1'b1);
      check("flush_block", 32'(obs_valid), 32'd0);
    end
    check("flush_idle", 32'(bus.idle), 32'd1);
    check("flush_out", 32'(bus.outstanding), 32'd0);
    cycle(3'b011, 1'b1, 1'b0, 1'b0);
    check("flush_resume", 32'(obs_valid), 32'd1);
    drain();

    // Asynchronous reset while a grant is locked
    repeat (2) cycle(3'b001, 1'b1, 1'b0, 1'b0);
    cycle(3'b001, 1'b0, 1'b0, 1'b0);
    check("lockrst_pre", 32'(bus.refill_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("lockrst_valid", 32'(bus.refill_valid), 32'd0);
    check("lockrst_ready", 32'(bus.req_ready), 32'd0);
    check("lockrst_out", 32'(bus.outstanding), 32'd0);
    check("lockrst_idle", 32'(bus.idle), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    fl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) fl = ~fl;
      cycle(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), fl);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
